core_lsu: RTL and testbench

//  MEM-stage load/store unit of the RV64IM pipeline, between EX/MEM and MEM/WB registers.

---
 rtl/core_lsu.sv | 119 +++++++++++
 tb/tb_core_lsu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/core_lsu.sv
// core_lsu: MEM-stage load/store unit with req/gnt/rvalid data bus, stall, timeout and load extension
module core_lsu #(
  parameter int XLEN     = 64,
  parameter int WAIT_MAX = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      rsd_idx_i,
  output logic            out_valid,
  output logic [XLEN-1:0] mem_data_o,
  output logic [4:0]      rsd_idx_o,
  output logic            err_o,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  output logic [7:0]      dbus_wstrb_o,
  input  logic            dbus_gnt_i,
  input  logic            dbus_rvalid_i,
  input  logic [XLEN-1:0] dbus_rdata_i
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_f3, r_a;
  logic            r_load, r_we, r_err;
  logic [4:0]      r_rsd;
  logic [7:0]      r_wstrb;
  logic [XLEN-1:0] r_addr, r_wdata, r_data;
  logic            w_accept, w_mem, w_illegal, w_mis, w_bad, w_to, w_sx;
  logic [7:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata, w_lane, w_ext;
  assign w_accept  = in_valid & (r_state == IDLE);
  assign w_mem     = mem_read | mem_write;
  assign w_illegal = (mem_read & mem_write) | (mem_read & (funct3 == 3'b111)) | (mem_write & funct3[2]);
  assign w_mis     = funct3[1:0] == 2'd1 ? addr_i[0] :
                     funct3[1:0] == 2'd2 ? |addr_i[1:0] :
                     funct3[1:0] == 2'd3 ? |addr_i[2:0] : 1'b0;
  assign w_bad     = w_mem & (w_illegal | w_mis);
  assign w_to      = r_cnt == CW'(WAIT_MAX - 1);
  assign w_wstrb   = funct3[1:0] == 2'd0 ? 8'h01 << addr_i[2:0] :
                     funct3[1:0] == 2'd1 ? 8'h03 << addr_i[2:0] :
                     funct3[1:0] == 2'd2 ? 8'h0F << addr_i[2:0] : 8'hFF;
  assign w_wdata   = funct3[1:0] == 2'd0 ? {8{wdata_i[7:0]}} :
                     funct3[1:0] == 2'd1 ? {4{wdata_i[15:0]}} :
                     funct3[1:0] == 2'd2 ? {2{wdata_i[31:0]}} : wdata_i;
  assign w_lane    = dbus_rdata_i >> {r_a, 3'b000};
  assign w_sx      = ~r_f3[2];
  assign w_ext     = r_f3[1:0] == 2'd0 ? {{(XLEN-8){w_sx & w_lane[7]}}, w_lane[7:0]} :
                     r_f3[1:0] == 2'd1 ? {{(XLEN-16){w_sx & w_lane[15]}}, w_lane[15:0]} :
                     r_f3[1:0] == 2'd2 ? {{(XLEN-32){w_sx & w_lane[31]}}, w_lane[31:0]} : w_lane;
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? ((w_mem & ~w_bad) ? REQ : DONE) : IDLE;
      REQ:     w_next = dbus_gnt_i ? RSP : (w_to ? DONE : REQ);
      RSP:     w_next = (dbus_rvalid_i | w_to) ? DONE : RSP;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    in_ready   = r_state == IDLE;
    dbus_req_o = r_state == REQ;
    out_valid  = r_state == DONE;
  end
  // Result registers load only on entry to DONE so they hold until the next completion
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_f3    <= '0;
      r_a     <= '0;
      r_load  <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_rsd   <= '0;
      r_wstrb <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_data  <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= '0;
        r_f3    <= funct3;
        r_a     <= addr_i[2:0];
        r_load  <= mem_read;
        r_we    <= mem_write;
        r_rsd   <= rsd_idx_i;
        r_addr  <= {addr_i[XLEN-1:3], 3'b000};
        r_wdata <= mem_write ? w_wdata : '0;
        r_wstrb <= mem_write ? w_wstrb : 8'h00;
      end else if (r_state == REQ || r_state == RSP) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state != DONE && w_next == DONE) begin
        r_data <= (r_state == RSP && dbus_rvalid_i && r_load) ? w_ext : '0;
        r_err  <= r_state == IDLE ? w_bad : ~(r_state == RSP && dbus_rvalid_i);
      end
    end
  end
  assign mem_data_o   = r_data;
  assign rsd_idx_o    = r_rsd;
  assign err_o        = r_err;
  assign dbus_we_o    = r_we;
  assign dbus_addr_o  = r_addr;
  assign dbus_wdata_o = r_wdata;
  assign dbus_wstrb_o = r_wstrb;
endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: directed and randomized checks of core_lsu against a byte-level reference model
module tb_core_lsu;
  localparam int WM = 4;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [63:0] addr_i = '0, wdata_i = '0, dbus_rdata_i = '0;
  logic [4:0]  rsd_idx_i = '0;
  logic        dbus_gnt_i = 1'b0, dbus_rvalid_i = 1'b0;
  logic        in_ready, out_valid, err_o, dbus_req_o, dbus_we_o;
  logic [63:0] mem_data_o, dbus_addr_o, dbus_wdata_o;
  logic [4:0]  rsd_idx_o;
  logic [7:0]  dbus_wstrb_o;
  int n_vec = 0, n_err = 0;

  core_lsu #(.XLEN(64), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr_i(addr_i), .wdata_i(wdata_i), .rsd_idx_i(rsd_idx_i),
    .out_valid(out_valid), .mem_data_o(mem_data_o), .rsd_idx_o(rsd_idx_o), .err_o(err_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_wstrb_o(dbus_wstrb_o), .dbus_gnt_i(dbus_gnt_i),
    .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_bad(input bit rd, input bit wr, input logic [2:0] f3, input logic [63:0] a);
    if (!rd && !wr) return 0;
    if (rd && wr) return 1;
    if (rd && f3 == 3'd7) return 1;
    if (wr && f3 > 3'd3) return 1;
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic logic [63:0] load_exp(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] rdata);
    logic [63:0] lane, mask, v;
    int n;
    n = nbytes(f3);
    lane = rdata >> (8 * (a % 8));
    if (n == 8) return lane;
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = lane & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [7:0] strb_exp(input logic [2:0] f3, input logic [63:0] a);
    int n;
    logic [15:0] s;
    n = nbytes(f3);
    s = 16'(((1 << n) - 1) << (a % 8));
    return s[7:0];
  endfunction

  function automatic logic [63:0] wdata_exp(input logic [2:0] f3, input logic [63:0] w);
    logic [63:0] r;
    int n;
    n = nbytes(f3);
    for (int i = 0; i < 8; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
    return r;
  endfunction

  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input logic [4:0] rsd, input logic [63:0] rdata,
                        input int gd, input int rvd);
    bit bad, bus;
    bad = is_bad(rd, wr, f3, a);
    bus = (rd || wr) && !bad;
    chk("ready_idle", in_ready, 1);
    in_valid = 1; mem_read = rd; mem_write = wr; funct3 = f3; addr_i = a; wdata_i = wd; rsd_idx_i = rsd;
    step();
    in_valid = 0; mem_read = 0; mem_write = 0;
    if (!bus) begin
      chk("ov_fast", out_valid, 1);
      chk("no_req", dbus_req_o, 0);
      chk("err_fast", err_o, bad);
      chk("data_fast", mem_data_o, 0);
      chk("rsd_fast", rsd_idx_o, rsd);
    end else begin
      chk("we", dbus_we_o, wr);
      chk("addr", dbus_addr_o, a & ~64'h7);
      chk("wstrb", dbus_wstrb_o, wr ? strb_exp(f3, a) : 8'h00);
      if (wr) chk("wdata", dbus_wdata_o, wdata_exp(f3, wd));
      for (int k = 0; k <= gd; k++) begin
        dbus_gnt_i = (k == gd);
        chk("req", dbus_req_o, 1);
        chk("stall", in_ready, 0);
        step();
      end
      dbus_gnt_i = 0;
      for (int k = 0; k <= rvd; k++) begin
        dbus_rvalid_i = (k == rvd);
        dbus_rdata_i = rdata;
        chk("req_drop", dbus_req_o, 0);
        chk("ov_rsp", out_valid, 0);
        step();
      end
      dbus_rvalid_i = 0;
      chk("ov_done", out_valid, 1);
      chk("err_done", err_o, 0);
      chk("data_done", mem_data_o, rd ? load_exp(f3, a, rdata) : 64'd0);
      chk("rsd_done", rsd_idx_o, rsd);
    end
    step();
    chk("ov_pulse", out_valid, 0);
    chk("ready_back", in_ready, 1);
  endtask

  initial begin
    bit rd, wr;
    logic [2:0] f3;
    logic [63:0] a;
    int kind, gd, rvd;
    step(); step();
    chk("rst_ready", in_ready, 1);
    chk("rst_ov", out_valid, 0);
    chk("rst_err", err_o, 0);
    chk("rst_data", mem_data_o, 0);
    chk("rst_rsd", rsd_idx_o, 0);
    chk("rst_req", dbus_req_o, 0);
    chk("rst_we", dbus_we_o, 0);
    chk("rst_addr", dbus_addr_o, 0);
    chk("rst_wdata", dbus_wdata_o, 0);
    chk("rst_wstrb", dbus_wstrb_o, 0);
    rst = 0;
    step();
    run_op(1, 0, 3'b000, 64'h1003, 0, 5'd3, 64'h0000_0000_8000_0000, 0, 0);
    chk("lb_neg", mem_data_o, 64'hFFFF_FFFF_FFFF_FF80);
    run_op(1, 0, 3'b110, 64'h2004, 0, 5'd7, 64'hDEAD_BEEF_0000_0000, 0, 0);
    chk("lwu", mem_data_o, 64'h0000_0000_DEAD_BEEF);
    run_op(0, 1, 3'b001, 64'h3006, 64'h1234, 5'd0, 0, 1, 0);
    chk("sh_wstrb", dbus_wstrb_o, 8'hC0);
    chk("sh_wdata", dbus_wdata_o, 64'h1234_1234_1234_1234);
    chk("sh_addr", dbus_addr_o, 64'h3000);
    run_op(1, 0, 3'b010, 64'h4002, 0, 5'd9, 0, 0, 0);
    chk("lw_mis_err", err_o, 1);
    run_op(0, 0, 3'b000, 64'h5001, 0, 5'd4, 0, 0, 0);
    // LD whose grant never arrives must time out after WM request cycles
    in_valid = 1; mem_read = 1; funct3 = 3'b011; addr_i = 64'h5000; rsd_idx_i = 5'd11;
    step();
    in_valid = 0; mem_read = 0;
    for (int k = 0; k < WM; k++) begin
      chk("to_req", dbus_req_o, 1);
      chk("to_stall", in_ready, 0);
      chk("to_ov", out_valid, 0);
      step();
    end
    chk("to_ov_done", out_valid, 1);
    chk("to_err", err_o, 1);
    chk("to_data", mem_data_o, 0);
    chk("to_req_drop", dbus_req_o, 0);
    step();
    chk("to_ready", in_ready, 1);
    // Reset while waiting in RSP, then a stray rvalid while idle
    in_valid = 1; mem_read = 1; funct3 = 3'b011; addr_i = 64'h6000; rsd_idx_i = 5'd12;
    step();
    in_valid = 0; mem_read = 0; dbus_gnt_i = 1;
    step();
    dbus_gnt_i = 0; rst = 1;
    step();
    rst = 0;
    chk("mid_rst_req", dbus_req_o, 0);
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    dbus_rvalid_i = 1; dbus_rdata_i = 64'h1111_2222_3333_4444;
    step();
    dbus_rvalid_i = 0;
    chk("stray_ov", out_valid, 0);
    chk("stray_ready", in_ready, 1);
    run_op(1, 0, 3'b011, 64'h7008, 0, 5'd13, 64'h0123_4567_89AB_CDEF, 0, 1);
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 7);
      rd = (kind < 3) || (kind == 7);
      wr = (kind >= 3 && kind < 6) || (kind == 7);
      f3 = wr && !rd ? (($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3)))
                     : 3'($urandom_range(0, 7));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~64'(nbytes(f3) - 1);
      gd = $urandom_range(0, 1);
      rvd = gd ? 0 : $urandom_range(0, 1);
      run_op(rd, wr, f3, a, {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom}, gd, rvd);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
